// File: rtl/gx4000_pkg.sv
// Shared constants and types for the Plus/GX4000 cartridge read path.
package gx4000_pkg;

  localparam logic [2:0] RMR2_TAG   = 3'b101;
  localparam logic [1:0] WIN_0000   = 2'b00;
  localparam logic [1:0] WIN_4000   = 2'b01;
  localparam logic [1:0] WIN_8000   = 2'b10;
  localparam logic [1:0] WIN_ASIC   = 2'b11;
  localparam logic [4:0] BASIC_PAGE = 5'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_HOLD
  } reader_state_t;

endpackage

// File: rtl/gx4000_cart_map.sv
// RMR2 / upper-ROM page registers and the combinational cartridge address map.
module gx4000_cart_map
  import gx4000_pkg::*;
#(
  parameter logic [24:0] CART_BASE = 25'h0000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        plus_mode,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_wr,
  input  logic        cpu_iorq,
  input  logic        rom_lo_en,
  input  logic        rom_hi_en,
  output logic        cart_sel,
  output logic [24:0] map_addr
);

  logic [2:0] lower_bank;
  logic [1:0] lo_window;
  logic [4:0] upper_page;
  logic       lower_hit;
  logic       upper_hit;
  logic [4:0] page;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lower_bank <= 3'd0;
      lo_window  <= WIN_0000;
      upper_page <= BASIC_PAGE;
    end else if (plus_mode && cpu_wr && cpu_iorq) begin
      if (cpu_addr[15:14] == 2'b01 && cpu_data_in[7:5] == RMR2_TAG) begin
        lo_window  <= cpu_data_in[4:3];
        lower_bank <= cpu_data_in[2:0];
      end
      // DFxx with bit 7 clear falls back to the BASIC page rather than page 0
      if (cpu_addr[15:13] == 3'b110)
        upper_page <= cpu_data_in[7] ? cpu_data_in[4:0] : BASIC_PAGE;
    end
  end

  // The ASIC register page occupies the lower window, so it never maps to cart
  always_comb begin
    lower_hit = rom_lo_en && (lo_window != WIN_ASIC) && (cpu_addr[15:14] == lo_window);
    upper_hit = rom_hi_en && (cpu_addr[15:14] == 2'b11);
    page      = lower_hit ? {2'b00, lower_bank} : upper_page;
    map_addr  = CART_BASE + {6'b000000, page, cpu_addr[13:0]};
    cart_sel  = plus_mode && !cpu_iorq && (lower_hit || upper_hit);
  end

endmodule

// File: rtl/gx4000_cart_reader.sv
// Resolves CPU cartridge ROM reads into SDRAM reads, with a one-entry cache
// and a bounded wait so the CPU never stalls indefinitely.
module gx4000_cart_reader
  import gx4000_pkg::*;
#(
  parameter logic [24:0] CART_BASE = 25'h0000000,
  parameter int          TIMEOUT   = 64
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        plus_mode,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic        cpu_iorq,
  input  logic        rom_lo_en,
  input  logic        rom_hi_en,
  input  logic        ioctl_download,
  output logic [7:0]  cpu_data_out,
  output logic        cart_sel,
  output logic        cpu_wait,
  output logic        data_valid,
  output logic [24:0] sdram_addr,
  output logic        sdram_rd,
  input  logic        sdram_ack,
  input  logic [7:0]  sdram_dout,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT);

  reader_state_t state;
  logic [24:0]   map_addr;
  logic [CW-1:0] wait_cnt;
  logic          cache_valid;
  logic [24:0]   cache_tag;
  logic [7:0]    cache_data;

  gx4000_cart_map #(
    .CART_BASE (CART_BASE)
  ) u_map (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .plus_mode   (plus_mode),
    .cpu_addr    (cpu_addr),
    .cpu_data_in (cpu_data_in),
    .cpu_wr      (cpu_wr),
    .cpu_iorq    (cpu_iorq),
    .rom_lo_en   (rom_lo_en),
    .rom_hi_en   (rom_hi_en),
    .cart_sel    (cart_sel),
    .map_addr    (map_addr)
  );

  assign cpu_wait = cpu_rd && cart_sel && (state != ST_RESP) && (state != ST_HOLD);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      cache_valid  <= 1'b0;
      cache_tag    <= '0;
      cache_data   <= '0;
      cpu_data_out <= '0;
      data_valid   <= 1'b0;
      sdram_addr   <= CART_BASE;
      sdram_rd     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_rd && cart_sel && !ioctl_download) begin
            sdram_addr <= map_addr;
            if (cache_valid && cache_tag == map_addr) begin
              cpu_data_out <= cache_data;
              data_valid   <= 1'b1;
              state        <= ST_RESP;
            end else begin
              sdram_rd <= 1'b1;
              wait_cnt <= '0;
              state    <= ST_REQ;
            end
          end
        end
        // A dropped cpu_rd still lets the fetch finish so the cache gets filled
        ST_REQ: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (sdram_ack) begin
            sdram_rd     <= 1'b0;
            cache_valid  <= 1'b1;
            cache_tag    <= sdram_addr;
            cache_data   <= sdram_dout;
            cpu_data_out <= sdram_dout;
            data_valid   <= cpu_rd;
            state        <= cpu_rd ? ST_RESP : ST_IDLE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            sdram_rd     <= 1'b0;
            cpu_data_out <= 8'hFF;
            timeout_err  <= 1'b1;
            data_valid   <= cpu_rd;
            state        <= cpu_rd ? ST_RESP : ST_IDLE;
          end
        end
        ST_RESP: state <= ST_HOLD;
        ST_HOLD: if (!cpu_rd) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      // A cartridge reload may rewrite any byte, so the cached entry is stale
      if (ioctl_download) cache_valid <= 1'b0;
      if (!plus_mode) begin
        state      <= ST_IDLE;
        sdram_rd   <= 1'b0;
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/gx4000_cart_reader.md
Name: gx4000_cart_reader

Overview:
Read side of the Plus/GX4000 cartridge path: resolves CPU ROM reads against the cartridge image already written into SDRAM by the cartridge loader. It tracks the Plus RMR2 lower-ROM mapping and the upper-ROM page select, and converts a hit into a 25-bit SDRAM read with a req/ack handshake. A one-entry read cache and a timeout keep the CPU path deterministic. It sits between the CPU bus and the SDRAM arbiter, alongside the ASIC/IO blocks.

Parameters:
CART_BASE, 25'h0000000, SDRAM byte address of cartridge page 0
TIMEOUT, 64, cycles to wait for sdram_ack before aborting with 8'hFF

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
plus_mode  in  1  block active only when high; otherwise cart_sel=0 and no requests
cpu_addr  in  16  CPU address
cpu_data_in  in  8  CPU write data (I/O decode)
cpu_wr  in  1  CPU write strobe, one cycle
cpu_rd  in  1  CPU memory read, level held until data_valid seen
cpu_iorq  in  1  high = cpu_wr/cpu_rd is an I/O cycle
rom_lo_en  in  1  gate-array lower ROM enable
rom_hi_en  in  1  gate-array upper ROM enable
ioctl_download  in  1  cartridge load in progress; invalidates cache
cpu_data_out  out  8  read data, valid when data_valid
cart_sel  out  1  current cpu_addr maps to cartridge (combinational)
cpu_wait  out  1  stall CPU: cart read pending
data_valid  out  1  one-cycle pulse, cpu_data_out valid
sdram_addr  out  25  SDRAM byte address
sdram_rd  out  1  read request, held until sdram_ack
sdram_ack  in  1  one-cycle ack, sdram_dout valid same cycle
sdram_dout  in  8  SDRAM read data
timeout_err  out  1  sticky, set on any timeout, cleared by reset

Behaviour:
- Reset: lower_bank=0, lo_window=2'b00 (0000-3FFF), upper_page=5'd1, cache invalid, state IDLE; all outputs 0 except sdram_addr=CART_BASE.
- I/O decode (cpu_wr & cpu_iorq & plus_mode): addr[15:14]=2'b01 and data[7:5]=3'b101 -> RMR2: lo_window=data[4:3], lower_bank=data[2:0]; lo_window=2'b11 (ASIC page) disables the cart lower window. addr[15:13]=3'b110 (DFxx): data[7]=1 -> upper_page=data[4:0], else upper_page=1.
- Mapping: lower hit = rom_lo_en & lo_window!=3 & cpu_addr[15:14]==lo_window -> page={2'b0,lower_bank}; else upper hit = rom_hi_en & cpu_addr[15:14]==2'b11 -> page=upper_page. Lower takes priority. sdram_addr=CART_BASE+{page,cpu_addr[13:0]} (19-bit offset, zero-extended, mod 2^25).
- cart_sel = plus_mode & ~cpu_iorq & (lower|upper hit). cpu_wait = cpu_rd & cart_sel & state!=RESP & state!=HOLD.
- FSM:
  IDLE: cpu_rd & cart_sel -> latch address; cache valid & tag==address -> RESP (data 1 cycle after cpu_rd); else REQ.
  REQ: sdram_rd=1, counter++. sdram_ack -> load cache {tag,data}, -> RESP. Counter reaches TIMEOUT-1 without ack -> data=8'hFF, timeout_err=1, cache not updated, -> RESP.
  RESP: data_valid=1, cpu_data_out held -> HOLD.
  HOLD: wait cpu_rd=0 -> IDLE (one read per cpu_rd assertion).
- sdram_addr is registered at IDLE exit and stable throughout REQ.
- Ack outside REQ is ignored. Ack on the same cycle as the timeout: ack wins.
- ioctl_download=1 clears cache valid every cycle and blocks IDLE->REQ/RESP (cpu_wait stays high).
- cpu_rd dropped during REQ: the request completes; the result fills the cache; then -> IDLE directly.
- Bank-register writes during REQ affect only the next access.
- Reset mid-REQ drops sdram_rd on the next edge.
- plus_mode=0: IDLE, no requests, cpu_wait=0.

Decomposition:
- Shared package gx4000_pkg: RMR2 tag value 3'b101, window encodings, BASIC page constant 5'd1, FSM state enum.
- One sub-module, gx4000_cart_map: register decode plus combinational page/address mapping. FSM and cache stay in the top.

Test Plan:
- After reset, cpu_rd at 16'h0100 with rom_lo_en=1 -> sdram_addr=CART_BASE+25'h0100; ack with 8'hA5 -> data_valid pulse, cpu_data_out=8'hA5.
- I/O write 0x7F00 with 8'hAB (window 01, bank 3), read 16'h4010 -> sdram_addr=CART_BASE+25'h0C010.
- I/O write DFxx with 8'h85, rom_hi_en=1, read 16'hC000 -> offset 25'h14000. Then write 8'h07, read again -> page 1, offset 25'h04000.
- Read 16'h0200 twice -> one sdram_rd only; second data_valid 1 cycle after cpu_rd. Pulse ioctl_download, read again -> new sdram_rd.
- No ack for TIMEOUT cycles -> cpu_data_out=8'hFF, timeout_err=1 (sticky), next request proceeds normally.
- Reset asserted in REQ -> sdram_rd=0 next cycle. Late ack ignored; a following read is serviced correctly.
